bmp_stream_writer: RTL and testbench
====================================

# bmp_stream_writer

Downstream consumer of the two-pixel-per-clock image stream (VSYNC, HSYNC, DATA_R0..DATA_B1) produced by the image-read/enhancement stage. It turns each frame into a complete 24-bit BMP byte image and delivers it as 6-byte beats on a valid/ready output, so a file dumper, DMA or UART bridge can write a viewable result. Each frame starts with a 54-byte header (exactly 9 beats), followed by the pixel payload. Rows are in arrival order, which the header declares as top-down (negative height).

## Interface
- WIDTH, 768: pixels per row; must be even and a multiple of 4 so no BMP row padding is needed.
- HEIGHT, 512: rows per frame.
- FIFO_DEPTH, 16: output buffer depth in beats; a power of 2, at least 16.

- HCLK  in  1  clock.
- HRESETn  in  1  reset; asynchronous, active-low.
- VSYNC  in  1  high during the upstream start-up period; its rising edge starts a frame.
- HSYNC  in  1  high when the DATA_* inputs carry a valid two-pixel beat.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- OUT_DATA  out  48  beat; byte k is on bits [8k+7:8k] and is the k-th file byte of the beat.
- OUT_VALID  out  1  OUT_DATA is valid.
- OUT_READY  in  1  consumer accepts the beat.
- FRAME_DONE  out  1  one-cycle pulse when the last beat of a frame is accepted.
- OVERFLOW  out  1  sticky: a pixel beat was dropped because the FIFO was full.
- PROTO_ERR  out  1  sticky: HSYNC outside PIXELS, or a VSYNC rise outside IDLE/DONE.

## Operation
- **FSM states:** IDLE, HEADER, PIXELS, DONE.
- **IDLE → HEADER:** on a VSYNC rising edge. The edge is detected with a registered copy of VSYNC that resets to 0.
- **HEADER:** pushes one header beat per cycle while the FIFO is not full, using header index 0..8. After beat 8 is pushed, go to PIXELS.
- **PIXELS:**
  - Each HSYNC cycle pushes the beat B0,G0,R0,B1,G1,R1 (byte 0 = B0).
  - The pixel-beat counter counts HSYNC cycles, whether the beat is pushed or dropped.
  - When the counter reaches WIDTH*HEIGHT/2, go to DONE.
- **Full FIFO in PIXELS:** drop the beat, set OVERFLOW, and still count it.
- **DONE:**
  - Wait until the FIFO is empty, then pulse FRAME_DONE on the cycle the final beat is accepted.
  - Then go to IDLE.
  - A VSYNC rise while in DONE is recorded and causes an immediate transition to HEADER once the FIFO drains.
- **Protocol errors:**
  - HSYNC in IDLE, HEADER or DONE: the beat is dropped and PROTO_ERR is set.
  - VSYNC rise in HEADER or PIXELS: PROTO_ERR is set, the FIFO is flushed, the counters are cleared, and the FSM restarts in HEADER.
- **Header bytes (little-endian fields, 54 bytes total):**
  - 'B' 0x42, 'M' 0x4D.
  - File size, 32 bits: 54 + 3*WIDTH*HEIGHT.
  - Reserved, 32 bits: 0.
  - Pixel-data offset, 32 bits: 54.
  - DIB header size, 32 bits: 40.
  - Width, 32 bits: WIDTH.
  - Height, 32 bits: two's complement of HEIGHT.
  - Planes, 16 bits: 1.
  - Bits per pixel, 16 bits: 24.
  - Compression, 32 bits: 0.
  - Image size, 32 bits: 3*WIDTH*HEIGHT.
  - X and Y resolution, 32 bits each: 0.
  - Colours used and important colours, 32 bits each: 0.
- **Widths:**
  - Pixel counter is $clog2(WIDTH*HEIGHT/2+1) bits.
  - Header constants are computed at elaboration time in 32-bit arithmetic.

## Timing
- **Reset values:**
  - OUT_DATA = 0, OUT_VALID = 0, FRAME_DONE = 0, OVERFLOW = 0, PROTO_ERR = 0.
  - FSM = IDLE; FIFO empty.
  - Sticky flags clear only on reset.
- **Latency:** a beat pushed in cycle N into an empty FIFO has OUT_VALID = 1 in cycle N+1. The FIFO output is registered and first-word-fall-through.
- **Handshake:**
  - A transfer occurs when OUT_VALID and OUT_READY are both high on a clock edge.
  - OUT_DATA and OUT_VALID stay stable while OUT_VALID = 1 and OUT_READY = 0.
- **Simultaneous events:** push and pop in the same cycle on a full FIFO succeeds; the pop frees the slot.
- **Throughput and stalls:**
  - Throughput is 1 beat per cycle, in and out.
  - HEADER finishes within the upstream VSYNC window (100 cycles) unless the consumer stalls.
- **Reset mid-frame:** everything is discarded immediately; no FRAME_DONE is produced.

## Structure
- **Package bmp_pkg:**
  - State enum.
  - BMP_HDR_BYTES = 54, HDR_BEATS = 9.
  - Header field offsets and the constant values (DIB 40, 24 bpp).
  - Header-beat function hdr_beat(idx, W, H) returning 48 bits.
- **Sub-module beat_fifo:**
  - Synchronous FWFT FIFO: 48-bit data, depth FIFO_DEPTH.
  - Signals: push, pop, flush, full, empty, count.

## Test plan
- **Single frame, WIDTH=768, HEIGHT=512, OUT_READY=1:**
  - First beat = 0x0012_0036_4D42.
  - 9 header beats, then 196608 pixel beats.
  - FRAME_DONE pulses once.
  - File byte 22..25 = 0x00,0xFE,0xFF,0xFF (height -512).
- **Small frame, WIDTH=4, HEIGHT=2, pixel beat R0=1,G0=2,B0=3,R1=4,G1=5,B1=6:**
  - Beat = 0x04_05_06_01_02_03.
  - Exactly 4 pixel beats follow the header.
- **Backpressure:**
  - Hold OUT_READY=0 for 40 cycles during PIXELS with FIFO_DEPTH=16.
  - OVERFLOW=1 after the 17th pending pixel beat.
  - Held OUT_DATA is stable; the pixel count still ends the frame.
- **Random OUT_READY at 50%, header + 8 lines:** the byte stream matches the reference model byte for byte, with no overflow when the input rate stays within the upstream timing.
- **VSYNC rise during PIXELS:** PROTO_ERR=1, FIFO flushed, and the next output beat is header beat 0.
- **HRESETn low for 1 cycle mid-header:** all outputs return to reset values, and the next VSYNC produces a clean frame.

Source files
------------

// File: rtl/bmp_pkg.sv
// BMP stream writer shared definitions: FSM states, header layout and
// the header-beat generator used to emit the 54-byte file header.
package bmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIXELS,
    ST_DONE
  } state_t;

  localparam int BMP_HDR_BYTES = 54;
  localparam int HDR_BEATS     = 9;
  localparam int BEAT_BYTES    = 6;

  // Byte offsets of the header fields
  localparam int OFF_FSIZE  = 2;
  localparam int OFF_DATA   = 10;
  localparam int OFF_DIB    = 14;
  localparam int OFF_WIDTH  = 18;
  localparam int OFF_HEIGHT = 22;
  localparam int OFF_PLANES = 26;
  localparam int OFF_BPP    = 28;
  localparam int OFF_ISIZE  = 34;

  localparam logic [31:0] DIB_SIZE = 32'd40;
  localparam logic [31:0] BPP      = 32'd24;
  localparam logic [31:0] PLANES   = 32'd1;

  // Byte i (little-endian) of a 32-bit field
  function automatic logic [7:0] byte_of(input logic [31:0] v, input int i);
    logic [31:0] s;
    s = v >> (8 * i);
    return s[7:0];
  endfunction

  // File byte k of the header for a w x h top-down 24-bit image
  function automatic logic [7:0] hdr_byte(input int k, input logic [31:0] w,
                                          input logic [31:0] h);
    logic [31:0] img;
    logic [7:0]  b;
    img = 32'd3 * w * h;
    b   = 8'h00;
    if (k == 0)                                        b = 8'h42;
    else if (k == 1)                                   b = 8'h4D;
    else if (k >= OFF_FSIZE  && k < OFF_FSIZE + 4)     b = byte_of(img + 32'(BMP_HDR_BYTES), k - OFF_FSIZE);
    else if (k >= OFF_DATA   && k < OFF_DATA + 4)      b = byte_of(32'(BMP_HDR_BYTES), k - OFF_DATA);
    else if (k >= OFF_DIB    && k < OFF_DIB + 4)       b = byte_of(DIB_SIZE, k - OFF_DIB);
    else if (k >= OFF_WIDTH  && k < OFF_WIDTH + 4)     b = byte_of(w, k - OFF_WIDTH);
    else if (k >= OFF_HEIGHT && k < OFF_HEIGHT + 4)    b = byte_of(32'd0 - h, k - OFF_HEIGHT);
    else if (k >= OFF_PLANES && k < OFF_PLANES + 2)    b = byte_of(PLANES, k - OFF_PLANES);
    else if (k >= OFF_BPP    && k < OFF_BPP + 2)       b = byte_of(BPP, k - OFF_BPP);
    else if (k >= OFF_ISIZE  && k < OFF_ISIZE + 4)     b = byte_of(img, k - OFF_ISIZE);
    return b;
  endfunction

  // Six header bytes of beat idx, byte 0 in the low bits
  function automatic logic [47:0] hdr_beat(input logic [3:0] idx, input logic [31:0] w,
                                           input logic [31:0] h);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < BEAT_BYTES; k++)
      r[8*k +: 8] = hdr_byte(BEAT_BYTES * int'(idx) + k, w, h);
    return r;
  endfunction

endpackage

// File: rtl/bmp_stream_writer_fifo.sv
// First-word-fall-through beat FIFO. The head entry is read straight out of
// the storage flops, so a beat written into an empty FIFO is visible on the
// next cycle and stays put until popped.
module beat_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 48
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot the push lands in
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Turns the two-pixel-per-clock image stream into a 24-bit top-down BMP byte
// image: 9 header beats followed by one 6-byte beat per HSYNC cycle.
import bmp_pkg::*;

module bmp_stream_writer #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  input  logic [7:0]  DATA_R1,
  input  logic [7:0]  DATA_G1,
  input  logic [7:0]  DATA_B1,
  output logic [47:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        FRAME_DONE,
  output logic        OVERFLOW,
  output logic        PROTO_ERR
);
  localparam int PIX_BEATS = WIDTH * HEIGHT / 2;
  localparam int PW        = $clog2(PIX_BEATS + 1);
  localparam int CW        = $clog2(FIFO_DEPTH + 1);

  state_t        state, state_nx;
  logic [3:0]    hdr_idx, hdr_idx_nx;
  logic [PW-1:0] pix_cnt, pix_cnt_nx;
  logic          vs_pend, vs_pend_nx;
  logic          vsync_q, vs_rise;
  logic          push, pop, flush, can_push;
  logic          ovf_set, perr_set, frame_done;
  logic [47:0]   wdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign vs_rise    = VSYNC && !vsync_q;
  assign OUT_VALID  = !fifo_empty;
  assign pop        = OUT_VALID && OUT_READY;
  assign can_push   = !fifo_full || pop;
  assign FRAME_DONE = frame_done;

  beat_fifo #(.DEPTH(FIFO_DEPTH), .DW(48)) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (wdata),
    .rdata   (OUT_DATA),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next state, FIFO pushes and error/flag requests
  always_comb begin
    state_nx   = state;
    hdr_idx_nx = hdr_idx;
    pix_cnt_nx = pix_cnt;
    vs_pend_nx = vs_pend;
    push       = 1'b0;
    wdata      = '0;
    flush      = 1'b0;
    ovf_set    = 1'b0;
    perr_set   = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (HSYNC) perr_set = 1'b1;
        if (vs_rise) begin
          state_nx   = ST_HEADER;
          hdr_idx_nx = '0;
          pix_cnt_nx = '0;
        end
      end
      ST_HEADER: begin
        if (HSYNC) perr_set = 1'b1;
        if (vs_rise) begin
          // Restart the frame from scratch
          perr_set   = 1'b1;
          flush      = 1'b1;
          hdr_idx_nx = '0;
          pix_cnt_nx = '0;
        end else if (can_push) begin
          push  = 1'b1;
          wdata = hdr_beat(hdr_idx, 32'(WIDTH), 32'(HEIGHT));
          if (hdr_idx == 4'(HDR_BEATS - 1)) begin
            state_nx   = ST_PIXELS;
            hdr_idx_nx = '0;
          end else begin
            hdr_idx_nx = hdr_idx + 4'd1;
          end
        end
      end
      ST_PIXELS: begin
        if (vs_rise) begin
          perr_set   = 1'b1;
          flush      = 1'b1;
          state_nx   = ST_HEADER;
          hdr_idx_nx = '0;
          pix_cnt_nx = '0;
        end else if (HSYNC) begin
          // Dropped beats still count so the frame length stays fixed
          if (can_push) begin
            push  = 1'b1;
            wdata = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
          end else begin
            ovf_set = 1'b1;
          end
          pix_cnt_nx = pix_cnt + 1'b1;
          if (pix_cnt_nx == PW'(PIX_BEATS)) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (HSYNC) perr_set = 1'b1;
        if (vs_rise) vs_pend_nx = 1'b1;
        if (pop && fifo_count == CW'(1)) begin
          frame_done = 1'b1;
          vs_pend_nx = 1'b0;
          if (vs_pend || vs_rise) begin
            state_nx   = ST_HEADER;
            hdr_idx_nx = '0;
            pix_cnt_nx = '0;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control state and counters
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      hdr_idx <= '0;
      pix_cnt <= '0;
      vs_pend <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_nx;
      hdr_idx <= hdr_idx_nx;
      pix_cnt <= pix_cnt_nx;
      vs_pend <= vs_pend_nx;
      vsync_q <= VSYNC;
    end
  end

  // Sticky status flags, cleared only by reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      OVERFLOW  <= 1'b0;
      PROTO_ERR <= 1'b0;
    end else begin
      if (ovf_set)  OVERFLOW  <= 1'b1;
      if (perr_set) PROTO_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench for bmp_stream_writer: a small 8x8 instance for the frame
// scenarios and a default 768x512 instance for the full-size header.
module tb_bmp_stream_writer;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PB = W * H / 2;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic       HRESETn = 1'b0;
  logic       VSYNC = 1'b0, HSYNC = 1'b0;
  logic [7:0] r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
  logic       ready_drv = 1'b1, rand_en = 1'b0, rand_bit = 1'b0;
  logic       OUT_READY;
  logic [47:0] OUT_DATA;
  logic       OUT_VALID, FRAME_DONE, OVERFLOW, PROTO_ERR;

  logic       big_vsync = 1'b0;
  logic [47:0] big_data;
  logic       big_valid, big_fd, big_ovf, big_perr;

  assign OUT_READY = rand_en ? rand_bit : ready_drv;

  bmp_stream_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .FRAME_DONE(FRAME_DONE), .OVERFLOW(OVERFLOW), .PROTO_ERR(PROTO_ERR)
  );

  bmp_stream_writer dut_big (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(big_vsync), .HSYNC(1'b0),
    .DATA_R0(8'h00), .DATA_G0(8'h00), .DATA_B0(8'h00), .DATA_R1(8'h00), .DATA_G1(8'h00), .DATA_B1(8'h00),
    .OUT_DATA(big_data), .OUT_VALID(big_valid), .OUT_READY(1'b1),
    .FRAME_DONE(big_fd), .OVERFLOW(big_ovf), .PROTO_ERR(big_perr)
  );

  int total = 0, bad = 0;
  int fd_cnt = 0;
  logic [47:0] rx[$];

  // Hand-computed header for an 8x8 top-down 24-bit image (file size 246, image 192)
  logic [47:0] hdr_exp [9] = '{48'h0000_00F6_4D42, 48'h0036_0000_0000, 48'h0000_0028_0000,
                               48'hFFF8_0000_0008, 48'h0018_0001_FFFF, 48'h00C0_0000_0000,
                               48'h0, 48'h0, 48'h0};

  // Capture accepted beats and FRAME_DONE pulses away from the active edge
  always @(negedge HCLK) begin
    if (OUT_VALID && OUT_READY) rx.push_back(OUT_DATA);
    if (FRAME_DONE) fd_cnt++;
  end

  always @(posedge HCLK) begin
    #1;
    if (rand_en) rand_bit = 1'($urandom_range(0, 1));
  end

  function automatic logic [47:0] exp_pix(input int i);
    return {8'(6*i+4), 8'(6*i+5), 8'(6*i+6), 8'(6*i+1), 8'(6*i+2), 8'(6*i+3)};
  endfunction

  function automatic logic [47:0] exp_beat(input int i);
    return (i < 9) ? hdr_exp[i] : exp_pix(i - 9);
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic start_vsync(input int hold);
    VSYNC = 1'b1;
    repeat (hold) tick();
    VSYNC = 1'b0;
  endtask

  task automatic drive_pix(input int i);
    HSYNC = 1'b1;
    r0 = 8'(6*i+1); g0 = 8'(6*i+2); b0 = 8'(6*i+3);
    r1 = 8'(6*i+4); g1 = 8'(6*i+5); b1 = 8'(6*i+6);
    tick();
    HSYNC = 1'b0;
  endtask

  task automatic wait_frame();
    for (int c = 0; c < 400 && fd_cnt == 0; c++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) tick();
    HRESETn = 1'b1;
    tick();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", OUT_VALID); end
    total++; if (OUT_DATA !== 48'h0) begin bad++; $display("FAIL reset_data got=%h want=0", OUT_DATA); end
    total++; if ({FRAME_DONE, OVERFLOW, PROTO_ERR} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {FRAME_DONE, OVERFLOW, PROTO_ERR}); end
    total++; if (big_valid !== 1'b0) begin bad++; $display("FAIL reset_big_valid got=%b want=0", big_valid); end
  endtask

  task automatic test_big_header();
    logic [47:0] hb [9];
    int n;
    n = 0;
    big_vsync = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (big_valid) begin
        if (n < 9) hb[n] = big_data;
        n++;
      end
    end
    big_vsync = 1'b0;
    total++; if (n != 9) begin bad++; $display("FAIL big_hdr_beats got=%0d want=9", n); end
    total++; if (hb[0] !== 48'h0012_0036_4D42) begin bad++; $display("FAIL big_hdr_beat0 got=%h want=001200364d42", hb[0]); end
    total++; if ({hb[4][15:0], hb[3][47:32]} !== 32'hFFFF_FE00) begin bad++; $display("FAIL big_hdr_height got=%h want=fffffe00", {hb[4][15:0], hb[3][47:32]}); end
    total++; if (hb[3][31:0] !== 32'h0000_0300) begin bad++; $display("FAIL big_hdr_width got=%h want=00000300", hb[3][31:0]); end
  endtask

  task automatic test_frame();
    int errs;
    rx.delete(); fd_cnt = 0; ready_drv = 1'b1;
    start_vsync(12);
    for (int i = 0; i < PB; i++) drive_pix(i);
    wait_frame();
    total++; if (rx.size() != 9 + PB) begin bad++; $display("FAIL frame_len got=%0d want=%0d", rx.size(), 9 + PB); end
    for (int i = 0; i < 9 && i < rx.size(); i++) begin
      total++; if (rx[i] !== hdr_exp[i]) begin bad++; $display("FAIL frame_hdr%0d got=%h want=%h", i, rx[i], hdr_exp[i]); end
    end
    if (rx.size() > 9) begin
      total++; if (rx[9] !== 48'h04_05_06_01_02_03) begin bad++; $display("FAIL frame_pix0 got=%h want=040506010203", rx[9]); end
    end
    errs = 0;
    for (int i = 9; i < rx.size() && i < 9 + PB; i++) if (rx[i] !== exp_beat(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL frame_pixels bad_beats=%0d want=0", errs); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL frame_done got=%0d want=1", fd_cnt); end
    total++; if ({OVERFLOW, PROTO_ERR} !== 2'b00) begin bad++; $display("FAIL frame_flags got=%b want=00", {OVERFLOW, PROTO_ERR}); end
  endtask

  task automatic test_random_ready();
    int errs;
    rx.delete(); fd_cnt = 0; rand_en = 1'b1;
    start_vsync(12);
    for (int i = 0; i < PB; i++) begin
      drive_pix(i);
      repeat (3) tick();
    end
    wait_frame();
    rand_en = 1'b0;
    total++; if (rx.size() != 9 + PB) begin bad++; $display("FAIL rand_len got=%0d want=%0d", rx.size(), 9 + PB); end
    errs = 0;
    for (int i = 0; i < rx.size() && i < 9 + PB; i++) if (rx[i] !== exp_beat(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL rand_stream bad_beats=%0d want=0", errs); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL rand_done got=%0d want=1", fd_cnt); end
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL rand_overflow got=%b want=0", OVERFLOW); end
  endtask

  task automatic test_vsync_abort();
    rx.delete(); fd_cnt = 0; ready_drv = 1'b0;
    VSYNC = 1'b1;
    repeat (12) tick();
    VSYNC = 1'b0;
    for (int i = 0; i < 5; i++) drive_pix(i);
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL abort_pending got=%b want=1", OUT_VALID); end
    VSYNC = 1'b1;
    tick();
    total++; if (PROTO_ERR !== 1'b1) begin bad++; $display("FAIL abort_proto got=%b want=1", PROTO_ERR); end
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL abort_flush got=%b want=0", OUT_VALID); end
    ready_drv = 1'b1;
    repeat (11) tick();
    VSYNC = 1'b0;
    for (int i = 0; i < PB; i++) drive_pix(i);
    wait_frame();
    total++; if (rx.size() != 9 + PB) begin bad++; $display("FAIL abort_len got=%0d want=%0d", rx.size(), 9 + PB); end
    if (rx.size() > 0) begin
      total++; if (rx[0] !== hdr_exp[0]) begin bad++; $display("FAIL abort_first got=%h want=%h", rx[0], hdr_exp[0]); end
    end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL abort_done got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    int errs;
    rx.delete(); fd_cnt = 0; ready_drv = 1'b1;
    start_vsync(12);
    ready_drv = 1'b0;
    for (int i = 0; i < 16; i++) drive_pix(i);
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b want=0", OVERFLOW); end
    total++; if (OUT_DATA !== exp_pix(0)) begin bad++; $display("FAIL bp_head got=%h want=%h", OUT_DATA, exp_pix(0)); end
    drive_pix(16);
    total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", OVERFLOW); end
    for (int i = 17; i < PB; i++) drive_pix(i);
    repeat (40 - PB) tick();
    total++; if ({OUT_VALID, OUT_DATA} !== {1'b1, exp_pix(0)}) begin bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", OUT_VALID, OUT_DATA, exp_pix(0)); end
    total++; if (fd_cnt != 0) begin bad++; $display("FAIL bp_early_done got=%0d want=0", fd_cnt); end
    ready_drv = 1'b1;
    wait_frame();
    total++; if (rx.size() != 9 + 16) begin bad++; $display("FAIL bp_len got=%0d want=25", rx.size()); end
    errs = 0;
    for (int i = 0; i < rx.size() && i < 25; i++) if (rx[i] !== exp_beat(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_stream bad_beats=%0d want=0", errs); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_reset_mid_header();
    int errs;
    fd_cnt = 0; ready_drv = 1'b1;
    VSYNC = 1'b1;
    repeat (4) tick();
    HRESETn = 1'b0;
    VSYNC = 1'b0;
    #1;
    total++; if ({OUT_VALID, OVERFLOW, PROTO_ERR} !== 3'b000) begin bad++; $display("FAIL rst_mid got=%b want=000", {OUT_VALID, OVERFLOW, PROTO_ERR}); end
    tick();
    HRESETn = 1'b1;
    tick();
    total++; if (OUT_DATA !== 48'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", OUT_DATA); end
    total++; if (fd_cnt != 0) begin bad++; $display("FAIL rst_mid_done got=%0d want=0", fd_cnt); end
    rx.delete();
    start_vsync(12);
    for (int i = 0; i < PB; i++) drive_pix(i);
    wait_frame();
    errs = (rx.size() != 9 + PB) ? 1 : 0;
    for (int i = 0; i < rx.size() && i < 9 + PB; i++) if (rx[i] !== exp_beat(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL rst_clean_frame bad=%0d len=%0d want=0", errs, rx.size()); end
    total++; if ({fd_cnt == 1, PROTO_ERR} !== 2'b10) begin bad++; $display("FAIL rst_clean_flags done=%0d perr=%b want=1/0", fd_cnt, PROTO_ERR); end
    drive_pix(0);
    tick();
    total++; if ({PROTO_ERR, OUT_VALID} !== 2'b10) begin bad++; $display("FAIL idle_hsync got=%b want=10", {PROTO_ERR, OUT_VALID}); end
  endtask

  initial begin
    test_reset();
    test_big_header();
    test_frame();
    test_random_ready();
    test_vsync_abort();
    test_backpressure();
    test_reset_mid_header();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
